mac_acc_sequencer: RTL and testbench



---
 rtl/mac_acc_sequencer_if.sv | 30 +++
 rtl/mac_acc_sequencer.sv | 100 ++++++++++
 tb/tb_mac_acc_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_acc_sequencer_if.sv
// Command, operand and result streams of the serial dot-product sequencer.
// The slave modport is the sequencer side. The master modport is the side that
// issues commands, supplies operands and consumes results.
interface mac_acc_sequencer_if #(
  parameter int unsigned IFMAP_BITWIDTH = 16,
  parameter int unsigned W_BITWIDTH     = 8,
  parameter int unsigned OFMAP_BITWIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 10
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [LEN_WIDTH-1:0]      cmd_len;
  logic                      op_valid;
  logic                      op_ready;
  logic [W_BITWIDTH-1:0]     op_w;
  logic [IFMAP_BITWIDTH-1:0] op_ifmap;
  logic                      res_valid;
  logic                      res_ready;
  logic [OFMAP_BITWIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_len, op_valid, op_w, op_ifmap, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_w, op_ifmap, res_ready,
    output cmd_ready, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_acc_sequencer.sv
// Serial dot-product controller for a single registered MAC element. It takes
// a length N, streams N (weight, ifmap) pairs into the MAC, and chains the MAC
// output back in as the accumulator. The first term is forced to start from
// zero. After one drain cycle it returns the sum.
module mac_acc_sequencer #(
  parameter int unsigned IFMAP_BITWIDTH = 16,
  parameter int unsigned W_BITWIDTH     = 8,
  parameter int unsigned OFMAP_BITWIDTH = 32,
  parameter int unsigned LEN_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  mac_acc_sequencer_if.slave        bus,
  output logic [W_BITWIDTH-1:0]     mac_w_out,
  output logic [IFMAP_BITWIDTH-1:0] mac_ifmap_out,
  output logic [OFMAP_BITWIDTH-1:0] mac_acc_out,
  input  logic [OFMAP_BITWIDTH-1:0] mac_result_in,
  output logic                      busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
  logic                      first_q, first_d;
  logic [OFMAP_BITWIDTH-1:0] res_data_q, res_data_d;
  logic                      in_run, cmd_fire, op_fire;

  // Handshakes and MAC drive; MAC inputs are zero outside an accepted operand.
  always_comb begin
    in_run        = (state_q == StRun) && !rst;
    bus.cmd_ready = (state_q == StIdle) && !rst;
    bus.op_ready  = in_run;
    cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    op_fire       = bus.op_valid && in_run;
    bus.res_valid = (state_q == StDone);
    bus.res_data  = res_data_q;
    busy          = (state_q != StIdle);
    mac_w_out     = op_fire ? bus.op_w : '0;
    mac_ifmap_out = op_fire ? bus.op_ifmap : '0;
    // Feed the running sum back during stalls as well, so the MAC holds it.
    mac_acc_out   = (in_run && !first_q) ? mac_result_in : '0;
  end

  // Sequencing: accept command, count operands, drain one cycle, hold result.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    res_data_d  = res_data_q;
    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (bus.cmd_len == '0) begin
            state_d    = StDone;
            res_data_d = '0;
          end else begin
            state_d     = StRun;
            remaining_d = bus.cmd_len;
            first_d     = 1'b1;
          end
        end
      end
      StRun: begin
        if (op_fire) begin
          first_d     = 1'b0;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        res_data_d = mac_result_in;
        state_d    = StDone;
      end
      StDone: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      first_q     <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_sequencer.sv
// Self-checking bench for mac_acc_sequencer. It contains a behavioural MAC, a
// transaction-level reference model, and directed plus randomized stimulus.
module tb_mac_acc_sequencer;
  localparam int unsigned IW = 16;
  localparam int unsigned WW = 8;
  localparam int unsigned OW = 32;
  localparam int unsigned LW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_acc_sequencer_if #(
    .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW), .OFMAP_BITWIDTH(OW), .LEN_WIDTH(LW)
  ) bus ();

  logic [WW-1:0] mac_w;
  logic [IW-1:0] mac_x;
  logic [OW-1:0] mac_acc;
  logic [OW-1:0] mac_q;
  logic          busy;

  mac_acc_sequencer #(
    .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW), .OFMAP_BITWIDTH(OW), .LEN_WIDTH(LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .mac_w_out    (mac_w),
    .mac_ifmap_out(mac_x),
    .mac_acc_out  (mac_acc),
    .mac_result_in(mac_q),
    .busy         (busy)
  );

  // Registered MAC element, reset alongside the sequencer.
  always @(posedge clk) begin
    if (rst) mac_q <= '0;
    else     mac_q <= OW'(int'($signed(mac_w)) * int'($signed(mac_x))) + mac_acc;
  end

  // Reference model: a job is live from command accept until its result is taken.
  logic        m_active, m_valid;
  int          m_len, m_cnt, m_sum;
  logic [31:0] m_data;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0; m_valid <= 1'b0; m_len <= 0; m_cnt <= 0; m_sum <= 0; m_data <= '0;
    end else if (!m_active) begin
      if (bus.cmd_valid) begin
        m_active <= 1'b1;
        m_len    <= int'(bus.cmd_len);
        m_cnt    <= 0;
        m_sum    <= 0;
        if (bus.cmd_len == '0) begin
          m_valid <= 1'b1;
          m_data  <= '0;
        end
      end
    end else if (!m_valid) begin
      if (m_cnt < m_len) begin
        if (bus.op_valid) begin
          m_sum <= m_sum + int'($signed(bus.op_w)) * int'($signed(bus.op_ifmap));
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_valid <= 1'b1;
        m_data  <= m_sum;
      end
    end else if (bus.res_ready) begin
      m_valid  <= 1'b0;
      m_active <= 1'b0;
    end
  end

  int          n_vec = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic        seen_cmd_fire, seen_op_fire, seen_cmd_ready, seen_res_valid, seen_busy;
  logic [31:0] seen_res_data, seen_acc, seen_mac;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  task automatic compare_all();
    logic e_cr, e_or;
    e_cr = !rst && !m_active;
    e_or = !rst && m_active && !m_valid && (m_cnt < m_len);
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_cr));
    chk("op_ready", 32'(bus.op_ready), 32'(e_or));
    chk("busy", 32'(busy), 32'(m_active));
    chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
    chk("res_data", bus.res_data, m_data);
    chk("mac_w_out", 32'(mac_w), (e_or && bus.op_valid) ? 32'(bus.op_w) : 32'd0);
    chk("mac_ifmap_out", 32'(mac_x), (e_or && bus.op_valid) ? 32'(bus.op_ifmap) : 32'd0);
    chk("mac_acc_out", mac_acc, e_or ? 32'(m_sum) : 32'd0);
  endtask

  // One clock: sample and check mid-cycle, then return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    seen_cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    seen_op_fire   = bus.op_valid && bus.op_ready;
    seen_cmd_ready = bus.cmd_ready;
    seen_res_valid = bus.res_valid;
    seen_res_data  = bus.res_data;
    seen_busy      = busy;
    seen_acc       = mac_acc;
    seen_mac       = mac_q;
    if (chk_en) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    for (int i = 0; i < 30; i++) begin
      step();
      if (seen_cmd_fire) begin
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    chk("cmd_accept_timeout", 32'd0, 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  // Leaves op_valid high so consecutive calls stream back-to-back.
  task automatic send_op(input int w, input int x);
    bus.op_valid = 1'b1;
    bus.op_w     = WW'(w);
    bus.op_ifmap = IW'(x);
    for (int i = 0; i < 30; i++) begin
      step();
      if (seen_op_fire) return;
    end
    chk("op_accept_timeout", 32'd0, 32'd1);
  endtask

  // Counts edges from the last handshake edge (inclusive) until res_valid is seen.
  task automatic wait_res(output int edges, output logic [31:0] data);
    edges = 0;
    data  = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      edges++;
      if (seen_res_valid) begin
        data = seen_res_data;
        return;
      end
    end
    chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  int          bw[4] = '{3, -1, 7, -128};
  int          bx[4] = '{2, 5, -4, 1};
  int          edges, len, w, x, sum;
  logic [31:0] data;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.op_valid = 1'b0;
    bus.op_w = '0; bus.op_ifmap = '0; bus.res_ready = 1'b0;

    // Reset held for three edges.
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(); step();
    chk("rst_res_valid", 32'(seen_res_valid), 32'd0);
    chk("rst_busy", 32'(seen_busy), 32'd0);
    chk("rst_cmd_ready", 32'(seen_cmd_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("cmd_ready_after_rst", 32'(seen_cmd_ready), 32'd1);

    // Basic: expected sum 6 - 5 - 28 - 128 = -155.
    bus.res_ready = 1'b1;
    send_cmd(4);
    for (int i = 0; i < 4; i++) begin
      send_op(bw[i], bx[i]);
      if (i == 0) chk("first_acc_zero", seen_acc, 32'd0);
    end
    bus.op_valid = 1'b0;
    wait_res(edges, data);
    chk("basic_latency", 32'(edges), 32'd2);
    chk("basic_result", data, -32'sd155);

    // Zero length, with junk operands offered that must be ignored.
    bus.op_valid = 1'b1; bus.op_w = 8'h55; bus.op_ifmap = 16'h1234;
    send_cmd(0);
    wait_res(edges, data);
    chk("zero_latency", 32'(edges), 32'd1);
    chk("zero_result", data, 32'd0);
    bus.op_valid = 1'b0;
    step();

    // Stall between ops 2 and 3; the result is then held under backpressure.
    bus.res_ready = 1'b0;
    send_cmd(4);
    send_op(bw[0], bx[0]);
    send_op(bw[1], bx[1]);
    bus.op_valid = 1'b0;
    repeat (3) begin
      step();
      chk("stall_mac_hold", seen_mac, 32'd1);
    end
    send_op(bw[2], bx[2]);
    send_op(bw[3], bx[3]);
    bus.op_valid = 1'b0;
    wait_res(edges, data);
    chk("stall_latency", 32'(edges), 32'd2);
    chk("stall_result", data, -32'sd155);
    bus.cmd_valid = 1'b1; bus.cmd_len = LW'(2);
    repeat (5) begin
      step();
      chk("hold_res_data", seen_res_data, -32'sd155);
      chk("hold_cmd_ready", 32'(seen_cmd_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    send_cmd(2);
    send_op(2, 3);
    send_op(4, 5);
    bus.op_valid = 1'b0;
    wait_res(edges, data);
    chk("second_result", data, 32'd26);

    // Reset in the middle of a job discards it.
    send_cmd(4);
    send_op(5, 6);
    send_op(-7, 8);
    bus.op_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_no_res", 32'(seen_res_valid), 32'd0);
    chk("midrst_idle", 32'(seen_cmd_ready), 32'd1);
    send_cmd(1);
    send_op(10, -3);
    bus.op_valid = 1'b0;
    wait_res(edges, data);
    chk("after_rst_result", data, -32'sd30);

    // Randomized jobs with stalls, junk commands and variable result backpressure.
    for (int t = 0; t < 30; t++) begin
      bus.res_ready = 1'b0;
      len = $urandom_range(0, 6);
      sum = 0;
      send_cmd(len);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin
          bus.op_valid  = 1'b0;
          bus.cmd_valid = 1'($urandom_range(0, 1));
          bus.cmd_len   = LW'($urandom_range(0, 5));
          step();
        end
        bus.cmd_valid = 1'b0;
        w = int'($signed(WW'($urandom)));
        x = int'($signed(IW'($urandom)));
        sum += w * x;
        send_op(w, x);
      end
      bus.op_valid = 1'b0;
      wait_res(edges, data);
      chk("rand_result", data, sum);
      repeat ($urandom_range(0, 3)) step();
      bus.res_ready = 1'b1;
      step();
    end
    bus.res_ready = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
